// File: rtl/perf_event_counter.sv
// Per-channel event counters for pipeline debug strobes, with edge or level counting,
// wrap or saturate on overflow, an atomic snapshot/clear, and a registered shadow readout.
module perf_event_counter #(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter bit SATURATE     = 1'b0,
  parameter int SEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CHANNELS-1:0] event_in,
  input  logic [NUM_CHANNELS-1:0] edge_mode,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    snapshot,
  input  logic                    rd_req,
  input  logic [SEL_WIDTH-1:0]    rd_sel,
  output logic                    rd_valid,
  output logic [COUNT_WIDTH-1:0]  rd_count,
  output logic                    rd_overflow,
  output logic [NUM_CHANNELS-1:0] overflow
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [SEL_WIDTH:0]     NUM_CH  = (SEL_WIDTH + 1)'(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] r_prev;
  logic [NUM_CHANNELS-1:0] w_hit;
  logic [NUM_CHANNELS-1:0] w_ovf;
  logic [NUM_CHANNELS-1:0] w_shadow_ovf;
  logic [COUNT_WIDTH-1:0]  w_shadow [NUM_CHANNELS];

  logic                    r_rd_valid;
  logic [COUNT_WIDTH-1:0]  r_rd_count;
  logic                    r_rd_overflow;

  // prev tracks the raw level even while disabled so re-enabling never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= event_in;
    end
  end

  assign w_hit = {NUM_CHANNELS{enable}} &
                 ((edge_mode & event_in & ~r_prev) | (~edge_mode & event_in));

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_ov;
    logic [COUNT_WIDTH-1:0] r_sh;
    logic                   r_sh_ov;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
        r_ov  <= 1'b0;
      end else if (clear) begin
        r_cnt <= '0;
        r_ov  <= 1'b0;
      end else if (w_hit[gi]) begin
        if (r_cnt == CNT_MAX) begin
          r_ov  <= 1'b1;
          r_cnt <= SATURATE ? CNT_MAX : '0;
        end else begin
          r_cnt <= r_cnt + COUNT_WIDTH'(1);
        end
      end
    end

    // Shadow takes the pre-update value, making snapshot+clear an atomic read-and-clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sh    <= '0;
        r_sh_ov <= 1'b0;
      end else if (snapshot) begin
        r_sh    <= r_cnt;
        r_sh_ov <= r_ov;
      end
    end

    assign w_ovf[gi]        = r_ov;
    assign w_shadow[gi]     = r_sh;
    assign w_shadow_ovf[gi] = r_sh_ov;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid    <= 1'b0;
      r_rd_count    <= '0;
      r_rd_overflow <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        if ({1'b0, rd_sel} < NUM_CH) begin
          r_rd_count    <= w_shadow[rd_sel];
          r_rd_overflow <= w_shadow_ovf[rd_sel];
        end else begin
          r_rd_count    <= '0;
          r_rd_overflow <= 1'b0;
        end
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_count    = r_rd_count;
  assign rd_overflow = r_rd_overflow;
  assign overflow    = w_ovf;

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: a wrapping and a saturating instance share stimulus and are
// checked every cycle against an arithmetic model, plus directed scenarios with literal results.
module tb_perf_event_counter;
  localparam int NCH  = 3;
  localparam int CW   = 4;
  localparam int SW   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] event_in = '0;
  logic [NCH-1:0] edge_mode = '0;
  logic           enable = 1'b0;
  logic           clear = 1'b0;
  logic           snapshot = 1'b0;
  logic           rd_req = 1'b0;
  logic [SW-1:0]  rd_sel = '0;

  logic           rd_valid_w, rd_valid_s;
  logic [CW-1:0]  rd_count_w, rd_count_s;
  logic           rd_overflow_w, rd_overflow_s;
  logic [NCH-1:0] overflow_w, overflow_s;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  perf_event_counter #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .SATURATE(1'b0), .SEL_WIDTH(SW)) dut_w (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .edge_mode(edge_mode), .enable(enable),
    .clear(clear), .snapshot(snapshot), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid_w),
    .rd_count(rd_count_w), .rd_overflow(rd_overflow_w), .overflow(overflow_w)
  );

  perf_event_counter #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .SATURATE(1'b1), .SEL_WIDTH(SW)) dut_s (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .edge_mode(edge_mode), .enable(enable),
    .clear(clear), .snapshot(snapshot), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid_s),
    .rd_count(rd_count_s), .rd_overflow(rd_overflow_s), .overflow(overflow_s)
  );

  // Model: index 0 = wrapping counter, index 1 = saturating counter.
  int m_cnt [2][NCH];
  bit m_ovf [2][NCH];
  int m_sh  [2][NCH];
  bit m_sho [2][NCH];
  bit m_prev[NCH];
  bit m_rv;
  int m_rc  [2];
  bit m_ro  [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_sh[d][c] = 0; m_sho[d][c] = 0;
        end
        m_rc[d] = 0; m_ro[d] = 0;
      end
      for (int c = 0; c < NCH; c++) m_prev[c] = 0;
      m_rv = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rd_req) begin
          int s;
          s = int'(rd_sel);
          m_rc[d] = (s < NCH) ? m_sh[d][s] : 0;
          m_ro[d] = (s < NCH) ? m_sho[d][s] : 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
          bit hit;
          if (snapshot) begin
            m_sh[d][c]  = m_cnt[d][c];
            m_sho[d][c] = m_ovf[d][c];
          end
          hit = enable && (edge_mode[c] ? (event_in[c] && !m_prev[c]) : event_in[c]);
          if (clear) begin
            m_cnt[d][c] = 0;
            m_ovf[d][c] = 0;
          end else if (hit) begin
            if (m_cnt[d][c] == MAXV) m_ovf[d][c] = 1;
            if (d == 0) m_cnt[d][c] = (m_cnt[d][c] + 1) % (MAXV + 1);
            else        m_cnt[d][c] = (m_cnt[d][c] < MAXV) ? m_cnt[d][c] + 1 : MAXV;
          end
        end
      end
      m_rv = rd_req;
      for (int c = 0; c < NCH; c++) m_prev[c] = event_in[c];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ovf_vec(input int d);
    int v;
    v = 0;
    for (int c = 0; c < NCH; c++) if (m_ovf[d][c]) v |= (1 << c);
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_rd_valid_w", 32'(rd_valid_w), int'(m_rv));
      chk("cyc_rd_valid_s", 32'(rd_valid_s), int'(m_rv));
      chk("cyc_rd_count_w", 32'(rd_count_w), m_rc[0]);
      chk("cyc_rd_count_s", 32'(rd_count_s), m_rc[1]);
      chk("cyc_rd_ovf_w", 32'(rd_overflow_w), int'(m_ro[0]));
      chk("cyc_rd_ovf_s", 32'(rd_overflow_s), int'(m_ro[1]));
      chk("cyc_overflow_w", 32'(overflow_w), ovf_vec(0));
      chk("cyc_overflow_s", 32'(overflow_s), ovf_vec(1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    snapshot = 1'b1; tick(1); snapshot = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
  endtask

  task automatic read_chk(input int sel, input int ew, input int eow, input int es, input int eos,
                          input string nm);
    rd_req = 1'b1; rd_sel = sel[SW-1:0];
    tick(1);
    rd_req = 1'b0;
    chk({nm, "_valid"}, 32'(rd_valid_w), 1);
    chk({nm, "_count_w"}, 32'(rd_count_w), ew);
    chk({nm, "_ovf_w"}, 32'(rd_overflow_w), eow);
    chk({nm, "_count_s"}, 32'(rd_count_s), es);
    chk({nm, "_ovf_s"}, 32'(rd_overflow_s), eos);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_overflow_w"}, 32'(overflow_w), 0);
    chk({nm, "_overflow_s"}, 32'(overflow_s), 0);
    chk({nm, "_valid"}, 32'(rd_valid_w), 0);
    chk({nm, "_count_w"}, 32'(rd_count_w), 0);
    chk({nm, "_count_s"}, 32'(rd_count_s), 0);
    chk({nm, "_ovf_w"}, 32'(rd_overflow_w), 0);
    chk({nm, "_ovf_s"}, 32'(rd_overflow_s), 0);
  endtask

  initial begin
    edge_mode = 3'b001;
    enable    = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Edge vs level on the same waveform.
    event_in = 3'b011; tick(10);
    event_in = 3'b000; tick(1);
    repeat (3) begin
      event_in = 3'b011; tick(1);
      event_in = 3'b000; tick(1);
    end
    snap();
    read_chk(0, 4, 0, 4, 0, "t1_ch0");
    tick(1);
    chk("t1_single_pulse", 32'(rd_valid_w), 0);
    read_chk(1, 13, 0, 13, 0, "t1_ch1");

    // Wrap vs saturate after 17 level hits, then clear.
    pulse_clear();
    event_in = 3'b100; tick(17);
    event_in = 3'b000;
    chk("t2_overflow_w", 32'(overflow_w), 4);
    chk("t2_overflow_s", 32'(overflow_s), 4);
    snap();
    read_chk(2, 1, 1, 15, 1, "t2_ovf");
    pulse_clear();
    chk("t2_clr_overflow_w", 32'(overflow_w), 0);
    chk("t2_clr_overflow_s", 32'(overflow_s), 0);
    snap();
    read_chk(2, 0, 0, 0, 0, "t2_clr");

    // Atomic snapshot + clear.
    pulse_clear();
    event_in = 3'b010; tick(5);
    snapshot = 1'b1; clear = 1'b1; tick(1);
    snapshot = 1'b0; clear = 1'b0;
    read_chk(1, 5, 0, 5, 0, "t3_old");
    snap();
    read_chk(1, 1, 0, 1, 0, "t3_restart");
    event_in = 3'b000;

    // Disabled edges are ignored; re-enable while high adds nothing.
    pulse_clear();
    enable = 1'b0;
    repeat (6) begin
      event_in = 3'b001; tick(1);
      event_in = 3'b000; tick(1);
    end
    snap();
    read_chk(0, 0, 0, 0, 0, "t4_disabled");
    event_in = 3'b001; tick(1);
    enable = 1'b1; tick(3);
    snap();
    read_chk(0, 0, 0, 0, 0, "t4_reenable");
    event_in = 3'b000; tick(1);
    event_in = 3'b001; tick(1);
    event_in = 3'b000;
    snap();
    read_chk(0, 1, 0, 1, 0, "t4_edge");

    // Readout select range and snapshot/read collision.
    pulse_clear();
    event_in = 3'b100; tick(7);
    event_in = 3'b000;
    snap();
    read_chk(2, 7, 0, 7, 0, "t5_sel2");
    read_chk(3, 0, 0, 0, 0, "t5_sel3");
    event_in = 3'b100; tick(2);
    event_in = 3'b000;
    snapshot = 1'b1;
    read_chk(2, 7, 0, 7, 0, "t5_snap_rd");
    snapshot = 1'b0;
    read_chk(2, 9, 0, 9, 0, "t5_after");

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      event_in = 3'($urandom);
      if ($urandom_range(0, 15) == 0) edge_mode = 3'($urandom);
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 39) == 0);
      snapshot = ($urandom_range(0, 5) == 0);
      rd_req   = ($urandom_range(0, 2) == 0);
      rd_sel   = SW'($urandom_range(0, 3));
      tick(1);
    end
    clear = 1'b0; snapshot = 1'b0; rd_req = 1'b0; enable = 1'b1;
    event_in = 3'b000; edge_mode = 3'b001;
    pulse_clear();

    // Asynchronous reset in mid-cycle with non-zero state.
    event_in = 3'b010; tick(17);
    snap();
    read_chk(1, 1, 1, 15, 1, "t6_pre");
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    event_in = 3'b001;
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    snap();
    read_chk(0, 1, 0, 1, 0, "t6_first_edge");
    event_in = 3'b000;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
